// File: rtl/mac_rx_deframer.sv
// rtl/mac_rx_deframer.sv - GMII receive deframer: preamble strip, DA filter, FCS check, AXI-RX byte stream
module mac_rx_deframer #(
    parameter logic [7:0] MAC_ADDRESS [0:5] = '{8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01},
    parameter bit         PROMISCUOUS       = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gmii_rx_dv,
    input  logic       gmii_rx_er,
    input  logic [7:0] gmii_rxd,
    output logic       axi_rx_tvalid,
    output logic [7:0] axi_rx_tdata,
    output logic       axi_rx_tlast,
    output logic       axi_rx_tuser,
    output logic       rx_frame_good,
    output logic       rx_frame_bad
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, END, DROP} state_t;

    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    state_t      state, state_next;
    logic        prev_dv;
    logic [2:0]  pre_cnt;
    logic [10:0] byte_cnt;
    logic [31:0] crc;
    logic        err, da_ucast, da_bcast;
    logic [7:0]  dl [0:4];

    logic dv_rise, start_frame, take_byte, push_out, emit_last;
    logic da_ucast_now, da_bcast_now, frame_bad;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign dv_rise      = gmii_rx_dv & ~prev_dv;
    assign da_ucast_now = da_ucast & (gmii_rxd == MAC_ADDRESS[byte_cnt[2:0]]);
    assign da_bcast_now = da_bcast & (gmii_rxd == 8'hFF);
    assign frame_bad    = (crc != CRC_RESIDUE) | err | (byte_cnt < 11'd64) | (byte_cnt > 11'd1518);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        take_byte   = 1'b0;
        push_out    = 1'b0;
        emit_last   = 1'b0;
        case (state)
            // END behaves like IDLE so a frame starting right after tlast is caught
            IDLE, END: begin
                state_next = IDLE;
                if (gmii_rx_dv) state_next = (dv_rise && gmii_rxd == 8'h55) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!gmii_rx_dv) state_next = IDLE;
                else if (gmii_rxd == 8'hD5) begin
                    state_next  = HEADER;
                    start_frame = 1'b1;
                end else if (gmii_rxd != 8'h55 || pre_cnt == 3'd7) state_next = DROP;
            end
            HEADER: begin
                if (!gmii_rx_dv) state_next = IDLE;
                else begin
                    take_byte = 1'b1;
                    if (byte_cnt == 11'd5 && !(da_ucast_now || da_bcast_now || PROMISCUOUS))
                        state_next = DROP;
                    else if (byte_cnt == 11'd11)
                        state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!gmii_rx_dv) begin
                    state_next = END;
                    emit_last  = (byte_cnt >= 11'd17);
                end else begin
                    take_byte = 1'b1;
                    push_out  = (byte_cnt >= 11'd17);
                end
            end
            DROP: begin
                if (!gmii_rx_dv) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // prev_dv starts high so a frame already in flight at reset release is dropped
            prev_dv       <= 1'b1;
            pre_cnt       <= 3'd0;
            byte_cnt      <= 11'd0;
            crc           <= 32'hFFFFFFFF;
            err           <= 1'b0;
            da_ucast      <= 1'b0;
            da_bcast      <= 1'b0;
            for (int i = 0; i < 5; i++) dl[i] <= 8'd0;
            axi_rx_tvalid <= 1'b0;
            axi_rx_tdata  <= 8'd0;
            axi_rx_tlast  <= 1'b0;
            axi_rx_tuser  <= 1'b0;
            rx_frame_good <= 1'b0;
            rx_frame_bad  <= 1'b0;
        end else begin
            prev_dv       <= gmii_rx_dv;
            axi_rx_tvalid <= 1'b0;
            axi_rx_tlast  <= 1'b0;
            axi_rx_tuser  <= 1'b0;
            rx_frame_good <= 1'b0;
            rx_frame_bad  <= 1'b0;

            if (state_next == PREAMBLE)
                pre_cnt <= (state == PREAMBLE) ? pre_cnt + 3'd1 : 3'd1;

            if (start_frame) begin
                crc      <= 32'hFFFFFFFF;
                byte_cnt <= 11'd0;
                err      <= 1'b0;
                da_ucast <= 1'b1;
                da_bcast <= 1'b1;
            end

            if (take_byte) begin
                crc      <= crc32_byte(crc, gmii_rxd);
                byte_cnt <= (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
                err      <= err | gmii_rx_er;
                if (byte_cnt < 11'd6) begin
                    da_ucast <= da_ucast_now;
                    da_bcast <= da_bcast_now;
                end
                if (state == PAYLOAD) begin
                    dl[0] <= gmii_rxd;
                    for (int i = 1; i < 5; i++) dl[i] <= dl[i-1];
                end
            end

            if (push_out || emit_last) begin
                axi_rx_tvalid <= 1'b1;
                axi_rx_tdata  <= dl[4];
            end

            if (emit_last) begin
                axi_rx_tlast  <= 1'b1;
                axi_rx_tuser  <= frame_bad;
                rx_frame_good <= ~frame_bad;
                rx_frame_bad  <= frame_bad;
            end
        end
    end

endmodule

// File: tb/tb_mac_rx_deframer.sv
// tb/tb_mac_rx_deframer.sv - directed bench for mac_rx_deframer
module tb_mac_rx_deframer;

    logic       clk = 1'b0;
    logic       reset;
    logic       gmii_rx_dv, gmii_rx_er;
    logic [7:0] gmii_rxd;

    logic       tvalid, tlast, tuser, good, bad;
    logic [7:0] tdata;
    logic       p_tvalid, p_tlast, p_tuser, p_good, p_bad;
    logic [7:0] p_tdata;

    mac_rx_deframer #(.PROMISCUOUS(1'b0)) dut (
        .clk(clk), .reset(reset),
        .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er), .gmii_rxd(gmii_rxd),
        .axi_rx_tvalid(tvalid), .axi_rx_tdata(tdata), .axi_rx_tlast(tlast),
        .axi_rx_tuser(tuser), .rx_frame_good(good), .rx_frame_bad(bad)
    );

    mac_rx_deframer #(.PROMISCUOUS(1'b1)) dut_p (
        .clk(clk), .reset(reset),
        .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er), .gmii_rxd(gmii_rxd),
        .axi_rx_tvalid(p_tvalid), .axi_rx_tdata(p_tdata), .axi_rx_tlast(p_tlast),
        .axi_rx_tuser(p_tuser), .rx_frame_good(p_good), .rx_frame_bad(p_bad)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rx_q[$];
    int n_last = 0, n_good = 0, n_bad = 0, n_pulse_err = 0, last_user = 0, last_cyc = 0;
    int np_bytes = 0, np_good = 0, np_last = 0;

    always @(negedge clk) begin
        if (tvalid) rx_q.push_back(int'(tdata));
        if (tvalid && tlast) begin
            n_last++;
            last_user = int'(tuser);
            last_cyc  = cyc;
        end
        if (good) n_good++;
        if (bad)  n_bad++;
        if (good != (tvalid & tlast & ~tuser) || bad != (tvalid & tlast & tuser)) n_pulse_err++;
        if (p_tvalid) np_bytes++;
        if (p_tvalid && p_tlast) np_last++;
        if (p_good) np_good++;
    end

    int n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    function automatic int rxb(input int idx);
        return (idx < rx_q.size()) ? rx_q[idx] : -1;
    endfunction

    logic [7:0] frame_q[$];
    logic [7:0] wire_q[$];

    // DA, SA 02:00:00:00:00:02, type 0800, payload 00,01,.. up to ndata bytes, then FCS
    task automatic build(input logic [47:0] da, input int ndata, input logic [7:0] fcs_xor);
        logic [47:0] sa;
        logic [31:0] c, fcs;
        logic [7:0]  b;
        sa = 48'h020000000002;
        frame_q.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < ndata; i++) begin
            if (i < 6)        b = da[47-8*i -: 8];
            else if (i < 12)  b = sa[47-8*(i-6) -: 8];
            else if (i == 12) b = 8'h08;
            else if (i == 13) b = 8'h00;
            else              b = 8'(i - 14);
            frame_q.push_back(b);
            c = crc_upd(c, b);
        end
        fcs = ~c;
        frame_q.push_back(fcs[7:0]);
        frame_q.push_back(fcs[15:8]);
        frame_q.push_back(fcs[23:16]);
        frame_q.push_back(fcs[31:24] ^ fcs_xor);
        wire_q.delete();
        for (int i = 0; i < 7; i++) wire_q.push_back(8'h55);
        wire_q.push_back(8'hD5);
        foreach (frame_q[i]) wire_q.push_back(frame_q[i]);
    endtask

    int fall_cyc = 0, rst_mark = 0;

    task automatic send(input int er_at, input int rst_at);
        for (int i = 0; i < wire_q.size(); i++) begin
            @(negedge clk);
            if (rst_at >= 0 && i == rst_at + 1) begin
                check("rst_tvalid", int'(tvalid), 0);
                check("rst_tlast", int'(tlast), 0);
                rst_mark = rx_q.size();
            end
            gmii_rx_dv = 1'b1;
            gmii_rxd   = wire_q[i];
            gmii_rx_er = (i == er_at);
            reset      = (i == rst_at);
        end
        @(negedge clk);
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        gmii_rxd   = 8'h00;
        reset      = 1'b0;
        fall_cyc   = cyc;
        repeat (12) @(negedge clk);
    endtask

    int s_q, s_last, s_good, s_bad, sp_bytes, sp_good;

    task automatic snap();
        s_q      = rx_q.size();
        s_last   = n_last;
        s_good   = n_good;
        s_bad    = n_bad;
        sp_bytes = np_bytes;
        sp_good  = np_good;
    endtask

    // expected stream per frame: 08, 00, 00, 01, ... repeating every 48 bytes for back-to-back frames
    task automatic check_result(input string tag, input int exp_n, input int exp_last,
                                input int exp_user, input int exp_good, input int exp_bad);
        int e;
        check({tag, "_count"}, rx_q.size() - s_q, exp_n);
        for (int k = 0; k < exp_n; k++) begin
            e = (k % 48 == 0) ? 8 : (k % 48 == 1) ? 0 : (k % 48) - 2;
            check({tag, "_data"}, rxb(s_q + k), e);
        end
        check({tag, "_tlast"}, n_last - s_last, exp_last);
        if (exp_last > 0) check({tag, "_tuser"}, last_user, exp_user);
        check({tag, "_good"}, n_good - s_good, exp_good);
        check({tag, "_bad"}, n_bad - s_bad, exp_bad);
    endtask

    initial begin
        reset      = 1'b1;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        gmii_rxd   = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_tvalid", int'(tvalid), 0);
        check("reset_tdata", int'(tdata), 0);
        check("reset_flags", int'({tlast, tuser, good, bad}), 0);
        repeat (2) @(negedge clk);

        build(48'hFFFFFFFFFFFF, 60, 8'h00);
        snap(); send(-1, -1);
        check_result("bcast", 48, 1, 0, 1, 0);
        check("bcast_last_byte", rxb(s_q + 47), 8'h2D);
        check("bcast_tlast_delay", last_cyc - fall_cyc, 1);

        build(48'hFFFFFFFFFFFF, 60, 8'h01);
        snap(); send(-1, -1);
        check_result("badfcs", 48, 1, 1, 0, 1);

        build(48'h02DEADBEEF02, 60, 8'h00);
        snap(); send(-1, -1);
        check_result("da_miss", 0, 0, 0, 0, 0);
        check("promisc_count", np_bytes - sp_bytes, 48);
        check("promisc_good", np_good - sp_good, 1);

        build(48'h02DEADBEEF01, 60, 8'h00);
        snap(); send(-1, -1);
        check_result("own_da", 48, 1, 0, 1, 0);

        build(48'hFFFFFFFFFFFF, 36, 8'h00);
        snap(); send(-1, -1);
        check_result("short40", 24, 1, 1, 0, 1);

        build(48'hFFFFFFFFFFFF, 12, 8'h00);
        snap(); send(-1, -1);
        check_result("runt16", 0, 0, 0, 0, 0);

        build(48'hFFFFFFFFFFFF, 60, 8'h00);
        wire_q[2] = 8'h5D;
        snap(); send(-1, -1);
        check_result("bad_pre", 0, 0, 0, 0, 0);

        build(48'hFFFFFFFFFFFF, 60, 8'h00);
        snap(); send(8 + 14 + 10, -1);
        check_result("rx_er", 48, 1, 1, 0, 1);

        snap(); send(-1, -1); send(-1, -1);
        check_result("two", 96, 2, 0, 2, 0);

        snap(); send(-1, 8 + 14 + 20);
        check("rst_no_tlast", n_last - s_last, 0);
        check("rst_no_pulse", (n_good - s_good) + (n_bad - s_bad), 0);
        check("rst_no_more_data", rx_q.size() - rst_mark, 0);

        snap(); send(-1, -1);
        check_result("after_rst", 48, 1, 0, 1, 0);

        check("pulse_align", n_pulse_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
